// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - PWM output stage with boundary-loaded shadow compares
// Watches count_val for wrap-around and drives pwm_out/overflow_pulse from shadows.
module pwm_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] count_val,
  input  logic [15:0] period,
  input  logic        upnotdown,
  input  logic        pwm_en,
  input  logic [15:0] compare1,
  input  logic [15:0] compare2,
  input  logic [1:0]  functions,
  input  logic        update_req,
  output logic        pwm_out,
  output logic        overflow_pulse,
  output logic        upd_pending
);

  typedef enum logic {OFF = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [15:0] prev_count;
  logic [15:0] sh_c1, sh_c2, c1_nxt, c2_nxt;
  logic [1:0]  sh_fn, fn_nxt;
  logic        pending, pending_nxt;
  logic        boundary, load, pwm_nxt;

  function automatic logic duty(input logic [1:0] fn, input logic [15:0] c1,
                                input logic [15:0] c2, input logic [15:0] cnt);
    logic r;
    if (fn[1])      r = (cnt >= c1) && (cnt < c2);
    else if (fn[0]) r = (cnt >= c1);
    else            r = (cnt < c1);
    return r;
  endfunction

  // A zero period never wraps, so pending updates simply wait.
  always_comb begin
    boundary = 1'b0;
    if (period != 16'd0) begin
      if (upnotdown) boundary = (prev_count == period) && (count_val == 16'd0);
      else           boundary = (prev_count == 16'd0) && (count_val == period);
    end
  end

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    pending_nxt = pending;
    case (state)
      OFF: begin
        load        = 1'b1;
        pending_nxt = 1'b0;
        if (pwm_en) state_nxt = RUN;
      end
      RUN: begin
        if (!pwm_en) begin
          state_nxt   = OFF;
          load        = 1'b1;
          pending_nxt = 1'b0;
        end else if (boundary) begin
          load        = 1'b1;
          pending_nxt = 1'b0;
        end else if (update_req) begin
          pending_nxt = 1'b1;
        end
      end
      default: state_nxt = OFF;
    endcase
    c1_nxt  = load ? compare1  : sh_c1;
    c2_nxt  = load ? compare2  : sh_c2;
    fn_nxt  = load ? functions : sh_fn;
    // Output is computed from the shadows as they will be after this edge.
    pwm_nxt = (state_nxt == RUN) && duty(fn_nxt, c1_nxt, c2_nxt, count_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= OFF;
      prev_count     <= 16'd0;
      sh_c1          <= 16'd0;
      sh_c2          <= 16'd0;
      sh_fn          <= 2'd0;
      pending        <= 1'b0;
      pwm_out        <= 1'b0;
      overflow_pulse <= 1'b0;
    end else begin
      state          <= state_nxt;
      prev_count     <= count_val;
      sh_c1          <= c1_nxt;
      sh_c2          <= c2_nxt;
      sh_fn          <= fn_nxt;
      pending        <= pending_nxt;
      pwm_out        <= pwm_nxt;
      overflow_pulse <= boundary;
    end
  end

  assign upd_pending = pending;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen
// Drives a modelled timer counter and compares against a period-level reference.
module tb_pwm_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] count_val, period, compare1, compare2;
  logic        upnotdown, pwm_en, update_req;
  logic [1:0]  functions;
  logic        pwm_out, overflow_pulse, upd_pending;

  int vectors = 0;
  int miscompares = 0;

  // Counter model: value, hold cycles per count, hold progress.
  int cnt = 0, hold = 1, hcnt = 0;
  int last_count;

  // Reference state: what the output stage "believes" at period level.
  bit          m_run, m_pend;
  int          m_prev;
  int          m_c1, m_c2;
  logic [1:0]  m_fn;
  logic        e_pwm, e_ovf, e_pend;

  pwm_gen dut (
    .clk(clk), .rst(rst), .count_val(count_val), .period(period),
    .upnotdown(upnotdown), .pwm_en(pwm_en), .compare1(compare1),
    .compare2(compare2), .functions(functions), .update_req(update_req),
    .pwm_out(pwm_out), .overflow_pulse(overflow_pulse), .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  function automatic bit duty_ref(input logic [1:0] fn, input int c1, input int c2, input int c);
    if (fn[1]) return (c >= c1) && (c < c2);
    if (fn[0]) return c >= c1;
    return c < c1;
  endfunction

  task automatic adv_counter();
    int p = int'(period);
    if (hcnt >= hold - 1) begin
      hcnt = 0;
      if (upnotdown) cnt = (cnt >= p) ? 0 : cnt + 1;
      else           cnt = (cnt == 0) ? p : cnt - 1;
    end else begin
      hcnt++;
    end
  endtask

  // Advance one clock: update the reference from the inputs about to be sampled.
  task automatic tick();
    bit wrapped;
    count_val = 16'(cnt);
    last_count = cnt;
    if (rst) begin
      m_run = 0; m_pend = 0; m_prev = 0; m_c1 = 0; m_c2 = 0; m_fn = 2'b00;
      e_pwm = 0; e_ovf = 0;
    end else begin
      wrapped = (period != 0) &&
                (upnotdown ? (m_prev == int'(period) && cnt == 0)
                           : (m_prev == 0 && cnt == int'(period)));
      if (!m_run || !pwm_en || wrapped) begin
        m_c1 = int'(compare1); m_c2 = int'(compare2); m_fn = functions;
      end
      m_pend = (m_run && pwm_en && !wrapped) ? (m_pend | update_req) : 1'b0;
      e_pwm  = pwm_en && duty_ref(m_fn, m_c1, m_c2, cnt);
      e_ovf  = wrapped;
      m_run  = pwm_en;
      m_prev = cnt;
    end
    e_pend = m_pend;
    @(posedge clk);
    #1;
    vectors++;
    update_req = 1'b0;
    adv_counter();
  endtask

  task automatic setup(input int per, input bit up, input int h);
    period = 16'(per); upnotdown = up; hold = h; hcnt = 0; cnt = up ? 0 : per;
  endtask

  task automatic test_reset();
    rst = 1'b1; pwm_en = 1'b1; update_req = 1'b1; compare1 = 16'd5; compare2 = 16'd9;
    functions = 2'b00; setup(9, 1, 1);
    tick(); tick();
    if (pwm_out !== 1'b0) begin $display("FAIL reset pwm_out got %b want 0", pwm_out); miscompares++; end
    if (overflow_pulse !== 1'b0) begin $display("FAIL reset overflow got %b want 0", overflow_pulse); miscompares++; end
    if (upd_pending !== 1'b0) begin $display("FAIL reset upd_pending got %b want 0", upd_pending); miscompares++; end
    rst = 1'b0; pwm_en = 1'b0;
    tick();
  endtask

  task automatic test_left_aligned();
    int highs = 0, pulses = 0;
    setup(9, 1, 1); compare1 = 16'd3; functions = 2'b00; pwm_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pwm_out !== e_pwm) begin $display("FAIL left pwm cyc %0d got %b want %b", i, pwm_out, e_pwm); miscompares++; end
      if (overflow_pulse !== e_ovf) begin $display("FAIL left ovf cyc %0d got %b want %b", i, overflow_pulse, e_ovf); miscompares++; end
      if (i >= 10) begin
        highs += int'(pwm_out); pulses += int'(overflow_pulse);
        if (overflow_pulse && last_count != 0) begin $display("FAIL left ovf_pos count %0d want 0", last_count); miscompares++; end
      end
    end
    if (highs != 9) begin $display("FAIL left duty highs got %0d want 9", highs); miscompares++; end
    if (pulses != 3) begin $display("FAIL left pulses got %0d want 3", pulses); miscompares++; end
  endtask

  task automatic test_right_unaligned();
    int c1s[3] = '{4, 2, 6};
    int c2s[3] = '{0, 6, 2};
    logic [1:0] fns[3] = '{2'b01, 2'b10, 2'b10};
    int want[3] = '{18, 12, 0};
    for (int k = 0; k < 3; k++) begin
      int highs = 0;
      pwm_en = 1'b0; compare1 = 16'(c1s[k]); compare2 = 16'(c2s[k]); functions = fns[k];
      tick();
      setup(9, 1, 1); pwm_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (pwm_out !== e_pwm) begin $display("FAIL mode%0d pwm cyc %0d got %b want %b", k, i, pwm_out, e_pwm); miscompares++; end
        if (i >= 10) highs += int'(pwm_out);
      end
      if (highs != want[k]) begin $display("FAIL mode%0d highs got %0d want %0d", k, highs, want[k]); miscompares++; end
    end
  endtask

  task automatic test_double_buffer();
    int guard;
    pwm_en = 1'b0; compare1 = 16'd3; functions = 2'b00; tick();
    setup(9, 1, 1); pwm_en = 1'b1;
    guard = 0;
    while (cnt != 5 && guard < 20) begin tick(); guard++; end
    if (cnt != 5) begin $display("FAIL dbuf reach5 got %0d want 5", cnt); miscompares++; end
    compare1 = 16'd7; update_req = 1'b1; tick();
    if (upd_pending !== 1'b1) begin $display("FAIL dbuf pending_set got %b want 1", upd_pending); miscompares++; end
    while (cnt != 0) begin
      tick();
      if (pwm_out !== 1'b0) begin $display("FAIL dbuf old_duty count %0d got %b want 0", last_count, pwm_out); miscompares++; end
      if (upd_pending !== 1'b1) begin $display("FAIL dbuf pending_hold got %b want 1", upd_pending); miscompares++; end
    end
    for (int c = 0; c <= 9; c++) begin
      if (c == 9) begin compare1 = 16'd2; update_req = 1'b1; end
      tick();
      if (pwm_out !== (c < 7)) begin $display("FAIL dbuf new_duty count %0d got %b want %b", c, pwm_out, c < 7); miscompares++; end
      if (c == 0 && upd_pending !== 1'b0) begin $display("FAIL dbuf pending_clr got %b want 0", upd_pending); miscompares++; end
    end
    // update_req landed in the cycle before the wrap; now request in the wrap cycle itself
    compare1 = 16'd2; update_req = 1'b1; tick();
    if (upd_pending !== 1'b0) begin $display("FAIL dbuf same_cycle pending got %b want 0", upd_pending); miscompares++; end
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (pwm_out !== (c < 2)) begin $display("FAIL dbuf c2_duty count %0d got %b want %b", c, pwm_out, c < 2); miscompares++; end
      if (pwm_out !== e_pwm) begin $display("FAIL dbuf model count %0d got %b want %b", c, pwm_out, e_pwm); miscompares++; end
    end
  endtask

  task automatic test_down_prescale();
    int pulses = 0;
    pwm_en = 1'b0; compare1 = 16'd3; functions = 2'b00; tick();
    setup(5, 0, 4); pwm_en = 1'b1;
    for (int i = 0; i < 72; i++) begin
      tick();
      if (overflow_pulse !== e_ovf) begin $display("FAIL down ovf cyc %0d got %b want %b", i, overflow_pulse, e_ovf); miscompares++; end
      if (pwm_out !== e_pwm) begin $display("FAIL down pwm cyc %0d got %b want %b", i, pwm_out, e_pwm); miscompares++; end
      if (i >= 24) begin
        pulses += int'(overflow_pulse);
        if (overflow_pulse && last_count != 5) begin $display("FAIL down ovf_pos count %0d want 5", last_count); miscompares++; end
      end
    end
    if (pulses != 2) begin $display("FAIL down pulses got %0d want 2", pulses); miscompares++; end
  endtask

  task automatic test_extremes();
    int highs, pulses;
    int c1s[2] = '{0, 65535};
    int want[2] = '{0, 20};
    for (int k = 0; k < 2; k++) begin
      highs = 0;
      pwm_en = 1'b0; compare1 = 16'(c1s[k]); functions = 2'b00; tick();
      setup(9, 1, 1); pwm_en = 1'b1;
      for (int i = 0; i < 20; i++) begin tick(); highs += int'(pwm_out); end
      if (highs != want[k]) begin $display("FAIL extreme c1=%0d highs got %0d want %0d", c1s[k], highs, want[k]); miscompares++; end
    end
    pulses = 0;
    pwm_en = 1'b0; tick();
    setup(0, 1, 1); pwm_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin compare1 = 16'd4; update_req = 1'b1; end
      tick(); pulses += int'(overflow_pulse);
    end
    if (pulses != 0) begin $display("FAIL period0 pulses got %0d want 0", pulses); miscompares++; end
    if (upd_pending !== 1'b1) begin $display("FAIL period0 pending got %b want 1", upd_pending); miscompares++; end
  endtask

  task automatic test_disable_reset();
    pwm_en = 1'b0; compare1 = 16'd5; functions = 2'b00; tick();
    setup(9, 1, 1); pwm_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    pwm_en = 1'b0; compare1 = 16'd8; tick();
    if (pwm_out !== 1'b0) begin $display("FAIL disable pwm got %b want 0", pwm_out); miscompares++; end
    pwm_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pwm_out !== (last_count < 8)) begin $display("FAIL disable follow count %0d got %b want %b", last_count, pwm_out, last_count < 8); miscompares++; end
    end
    compare1 = 16'd2; update_req = 1'b1; tick();
    if (upd_pending !== 1'b1) begin $display("FAIL rst pre_pending got %b want 1", upd_pending); miscompares++; end
    rst = 1'b1; tick();
    if ({pwm_out, overflow_pulse, upd_pending} !== 3'b000) begin
      $display("FAIL rst outputs got %b%b%b want 000", pwm_out, overflow_pulse, upd_pending); miscompares++;
    end
    rst = 1'b0; update_req = 1'b1; tick();
    if (upd_pending !== 1'b0) begin $display("FAIL rst state_off pending got %b want 0", upd_pending); miscompares++; end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 39) == 0) setup($urandom_range(0, 12), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) pwm_en = ~pwm_en;
      if ($urandom_range(0, 9) == 0) begin
        compare1 = 16'($urandom_range(0, 14)); compare2 = 16'($urandom_range(0, 14));
        functions = 2'($urandom_range(0, 3)); update_req = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) cnt = 0;
      tick();
      if (pwm_out !== e_pwm) begin $display("FAIL rand pwm cyc %0d got %b want %b", i, pwm_out, e_pwm); miscompares++; end
      if (overflow_pulse !== e_ovf) begin $display("FAIL rand ovf cyc %0d got %b want %b", i, overflow_pulse, e_ovf); miscompares++; end
      if (upd_pending !== e_pend) begin $display("FAIL rand pending cyc %0d got %b want %b", i, upd_pending, e_pend); miscompares++; end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pwm_en = 1'b0; update_req = 1'b0; upnotdown = 1'b1;
    period = 16'd9; compare1 = 16'd0; compare2 = 16'd0; functions = 2'b00; count_val = 16'd0;
    test_reset();
    test_left_aligned();
    test_right_unaligned();
    test_double_buffer();
    test_down_prescale();
    test_extremes();
    test_disable_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
